// File: rtl/innings_scorekeeper.sv
// innings_scorekeeper
// Per-ball scoring engine for the cricket game.
// Keeps runs, wickets and legal balls for both teams.
// Sequences innings 1, changeover, innings 2 and done.
// Supports a one-level undo that never crosses an innings.
module innings_scorekeeper (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        ball_valid,
    input  logic [3:0]  outcome,
    input  logic        next_inning,
    input  logic        gameOver,
    output logic [11:0] team1Data,
    output logic [11:0] team2Data,
    output logic [6:0]  team1Balls,
    output logic [6:0]  team2Balls,
    output logic [3:0]  wickets,
    output logic [7:0]  balls,
    output logic        battingTeam,
    output logic        event_ack,
    output logic        event_rej
);

    typedef enum logic [1:0] {INN1, CHG, INN2, DONE} state_t;

    localparam logic [3:0] MAX_WICKETS = 4'd10;
    localparam logic [6:0] MAX_BALLS   = 7'd120;

    state_t     state, state_nxt;
    logic [7:0] t1_runs, t2_runs, t1_runs_nxt, t2_runs_nxt;
    logic [3:0] t1_wkts, t2_wkts, t1_wkts_nxt, t2_wkts_nxt;
    logic [6:0] t1_balls, t2_balls, t1_balls_nxt, t2_balls_nxt;
    logic [7:0] snap_runs, snap_runs_nxt;
    logic [3:0] snap_wkts, snap_wkts_nxt;
    logic [6:0] snap_balls, snap_balls_nxt;
    logic       undo_ok, undo_ok_nxt;
    logic       batting_nxt, ack_nxt, rej_nxt;
    logic [3:0] wickets_nxt;
    logic [7:0] balls_nxt;

    logic       sel_t2;
    logic       at_limit;
    logic [7:0] cur_runs, new_runs, sat_runs;
    logic [3:0] cur_wkts, new_wkts;
    logic [6:0] cur_balls, new_balls;
    logic [3:0] add_runs;
    logic [8:0] run_sum;
    logic       write_team;

    // Next-state logic: innings sequencing, event application, undo and limits.
    always_comb begin
        state_nxt      = state;
        t1_runs_nxt    = t1_runs;
        t1_wkts_nxt    = t1_wkts;
        t1_balls_nxt   = t1_balls;
        t2_runs_nxt    = t2_runs;
        t2_wkts_nxt    = t2_wkts;
        t2_balls_nxt   = t2_balls;
        snap_runs_nxt  = snap_runs;
        snap_wkts_nxt  = snap_wkts;
        snap_balls_nxt = snap_balls;
        undo_ok_nxt    = undo_ok;
        batting_nxt    = battingTeam;
        ack_nxt        = 1'b0;
        rej_nxt        = 1'b0;
        write_team     = 1'b0;

        // Team 2 is the scoring target everywhere except innings 1.
        sel_t2    = (state != INN1);
        cur_runs  = sel_t2 ? t2_runs  : t1_runs;
        cur_wkts  = sel_t2 ? t2_wkts  : t1_wkts;
        cur_balls = sel_t2 ? t2_balls : t1_balls;
        at_limit  = (cur_wkts == MAX_WICKETS) || (cur_balls == MAX_BALLS);

        if (outcome <= 4'd6) begin
            add_runs = outcome;
        end else if ((outcome == 4'd8) || (outcome == 4'd9)) begin
            add_runs = 4'd1;
        end else begin
            add_runs = 4'd0;
        end
        run_sum  = {1'b0, cur_runs} + {5'd0, add_runs};
        sat_runs = run_sum[8] ? 8'hFF : run_sum[7:0];

        new_runs  = cur_runs;
        new_wkts  = cur_wkts;
        new_balls = cur_balls;

        if (gameOver) begin
            state_nxt   = DONE;
            undo_ok_nxt = 1'b0;
            rej_nxt     = ball_valid;
        end else begin
            case (state)
                INN1, INN2: begin
                    if ((state == INN1) && at_limit) begin
                        state_nxt   = CHG;
                        undo_ok_nxt = 1'b0;
                        rej_nxt     = ball_valid;
                    end else if (ball_valid) begin
                        if (at_limit) begin
                            rej_nxt = 1'b1;
                        end else if (outcome <= 4'd9) begin
                            snap_runs_nxt  = cur_runs;
                            snap_wkts_nxt  = cur_wkts;
                            snap_balls_nxt = cur_balls;
                            undo_ok_nxt    = 1'b1;
                            write_team     = 1'b1;
                            ack_nxt        = 1'b1;
                            new_runs       = sat_runs;
                            if (outcome <= 4'd7) begin
                                new_balls = cur_balls + 7'd1;
                            end
                            if (outcome == 4'd7) begin
                                new_wkts = cur_wkts + 4'd1;
                            end
                        end else if ((outcome == 4'd10) && undo_ok) begin
                            new_runs    = snap_runs;
                            new_wkts    = snap_wkts;
                            new_balls   = snap_balls;
                            undo_ok_nxt = 1'b0;
                            write_team  = 1'b1;
                            ack_nxt     = 1'b1;
                        end else begin
                            rej_nxt = 1'b1;
                        end
                    end
                end
                CHG: begin
                    if (next_inning) begin
                        state_nxt   = INN2;
                        undo_ok_nxt = 1'b0;
                        batting_nxt = 1'b1;
                    end
                    rej_nxt = ball_valid;
                end
                default: begin
                    rej_nxt = ball_valid;
                end
            endcase
        end

        if (write_team) begin
            if (sel_t2) begin
                t2_runs_nxt  = new_runs;
                t2_wkts_nxt  = new_wkts;
                t2_balls_nxt = new_balls;
            end else begin
                t1_runs_nxt  = new_runs;
                t1_wkts_nxt  = new_wkts;
                t1_balls_nxt = new_balls;
            end
        end

        wickets_nxt = (state_nxt == INN1) ? t1_wkts_nxt : t2_wkts_nxt;
        balls_nxt   = {1'b0, ((state_nxt == INN1) ? t1_balls_nxt : t2_balls_nxt)};
    end

    // State, counter and output registers; reset wins over every other input.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state       <= INN1;
            t1_runs     <= 8'd0;
            t1_wkts     <= 4'd0;
            t1_balls    <= 7'd0;
            t2_runs     <= 8'd0;
            t2_wkts     <= 4'd0;
            t2_balls    <= 7'd0;
            snap_runs   <= 8'd0;
            snap_wkts   <= 4'd0;
            snap_balls  <= 7'd0;
            undo_ok     <= 1'b0;
            battingTeam <= 1'b0;
            event_ack   <= 1'b0;
            event_rej   <= 1'b0;
            wickets     <= 4'd0;
            balls       <= 8'd0;
        end else begin
            state       <= state_nxt;
            t1_runs     <= t1_runs_nxt;
            t1_wkts     <= t1_wkts_nxt;
            t1_balls    <= t1_balls_nxt;
            t2_runs     <= t2_runs_nxt;
            t2_wkts     <= t2_wkts_nxt;
            t2_balls    <= t2_balls_nxt;
            snap_runs   <= snap_runs_nxt;
            snap_wkts   <= snap_wkts_nxt;
            snap_balls  <= snap_balls_nxt;
            undo_ok     <= undo_ok_nxt;
            battingTeam <= batting_nxt;
            event_ack   <= ack_nxt;
            event_rej   <= rej_nxt;
            wickets     <= wickets_nxt;
            balls       <= balls_nxt;
        end
    end

    assign team1Data  = {t1_runs, t1_wkts};
    assign team2Data  = {t2_runs, t2_wkts};
    assign team1Balls = t1_balls;
    assign team2Balls = t2_balls;

endmodule

// File: doc/innings_scorekeeper.md
# innings_scorekeeper

Per-ball scoring engine for the cricket game. It accepts one debounced ball-outcome event per press and keeps runs, wickets and legal balls for both teams. It sequences innings 1 → changeover → innings 2 → done, and supports a one-level undo. It sits directly upstream of the score comparator, which consumes its packed team data, ball counts and current-team wickets/balls.

## Interface
- No parameters; limits are fixed: 10 wickets, 120 legal balls, 255 runs.
- clk_fpga  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on the clk_fpga rising edge
- ball_valid  in  1  single-cycle pulse; outcome is valid this cycle
- outcome  in  4  0–6 = runs off a legal ball; 7 = wicket (legal, 0 runs); 8 = wide; 9 = no-ball; 10 = undo; 11–15 = illegal
- next_inning  in  1  single-cycle pulse; starts innings 2 from CHANGEOVER
- gameOver  in  1  level from the comparator; forces DONE
- team1Data  out  12  {runs[7:0], wickets[3:0]} of team 1
- team2Data  out  12  same packing for team 2
- team1Balls  out  7  legal balls bowled to team 1
- team2Balls  out  7  legal balls bowled to team 2
- wickets  out  4  wickets of the batting team (team 2 once out of INN1)
- balls  out  8  zero-extended legal balls of the batting team
- battingTeam  out  1  0 = team 1, 1 = team 2
- event_ack  out  1  pulse: event applied (includes a successful undo)
- event_rej  out  1  pulse: event ignored (illegal code, wrong state, empty undo)

## Operation
- States:
  - INN1 (reset state; battingTeam = 0)
  - CHG (changeover)
  - INN2 (battingTeam = 1)
  - DONE
- INN1 → CHG: on the cycle after an applied event leaves team 1 with wickets == 10 or balls == 120.
- CHG → INN2: on next_inning. next_inning in any other state is ignored, with no rej pulse.
- INN2 → CHG does not exist. INN2 stays put at the limit; further events are rejected until gameOver.
- Any state → DONE: whenever gameOver = 1. DONE exits only on reset.
- Event application (INN1/INN2 only; the batting team's counters only):
  - 0–6: runs += code; balls += 1.
  - 7: wickets += 1; balls += 1.
  - 8 / 9: runs += 1; balls unchanged.
- Events arriving in INN1/INN2 while that team is already at 10 wickets or 120 balls are rejected.
- Runs saturate at 255. A saturated wide/no-ball or scoring ball is still acked, and balls/wickets still advance.
- Undo:
  - Before applying any run/wicket/extra event, snapshot the batting team's {runs, wickets, balls} and set undo_ok.
  - Code 10 with undo_ok restores the snapshot, clears undo_ok and acks.
  - Code 10 without undo_ok is rejected.
  - undo_ok clears on entry to CHG, INN2 and DONE. Undo never crosses an innings.
  - An undo that takes team 1 below its limits is only possible while still in INN1, because the CHG transition clears undo_ok.
- Reset: all counters 0, undo_ok 0, state INN1.
  - Outputs: team1Data = 0, team2Data = 0, team1Balls = 0, team2Balls = 0, wickets = 0, balls = 0, battingTeam = 0, event_ack = 0, event_rej = 0.
- Reset wins over every simultaneous input, including a ball_valid in the same cycle.

## Timing
- All outputs are registered.
- Event sampled on edge N (ball_valid = 1):
  - counters and event_ack/event_rej update at edge N.
  - visible in cycle N+1.
  - ack/rej high for exactly one cycle.
- Limit detection uses post-update values. The state becomes CHG at edge N+1 and battingTeam flips at edge N+1 after next_inning is sampled.
- The comparator registers inningOver one cycle after wickets/balls change. This block does not depend on inningOver; it enforces limits itself.
- Back-to-back ball_valid on consecutive cycles is supported. Each event sees the previous event's result.
- gameOver and ball_valid in the same cycle: DONE entered, event rejected.

## Test plan
- Reset, then outcomes 4, 6, 1 → team1Data = {11, 0}, team1Balls = 3, balls = 3, three ack pulses, each one cycle after its ball_valid.
- Outcome 8 then 9 from team1 = {0,0,0} → runs = 2, team1Balls = 0. Then 6 ×43 (runs capped 255) → team1Data[11:4] = 255, team1Balls = 43.
- Ten wickets (code 7) in INN1 → wickets = 10, state CHG on the following cycle. Next code 2 → event_rej. next_inning → battingTeam = 1, wickets = 0, balls = 0, team1Data unchanged.
- 120 legal balls of code 1 in INN2 → team2Balls = 120, team2 runs = 120. Extra event → event_rej. Assert gameOver → DONE; next_inning and events → no counter change.
- Undo: code 3 (runs 3) then code 10 → runs 0, balls 0, ack. Second code 10 → rej. Code 7 then code 10 → wickets 0.
- Reset asserted together with ball_valid (code 6) mid-INN2 → all outputs 0, battingTeam = 0, no ack in the following cycle.
